xmerge_rr: RTL and testbench
============================

# xmerge_rr

Round-robin N-to-1 merge of native Versat memory-request interfaces onto one master port with independent read and write channels. Each channel serves one burst at a time and locks its grant until the master signals the last beat. Grants rotate fairly across requesters. It sits between Versat units (VRead/VWrite, DMA-side clients) and the single external memory port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width DATA_W/8
- N_SLAVES, 4, number of slave ports, ≥1
- LEN_W, 8, burst length field width; a burst is len+1 beats
- SLV_W, derived: N_SLAVES>1 ? $clog2(N_SLAVES) : 1, slave index width
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- s_valid_i  in  N_SLAVES  per-slave request valid
- s_ready_o  out  N_SLAVES  per-slave beat accepted
- s_last_o  out  N_SLAVES  per-slave last beat of burst
- s_addr_i  in  ADDR_W*N_SLAVES  packed addresses, slave k at [k*ADDR_W +: ADDR_W]
- s_wdata_i  in  DATA_W*N_SLAVES  packed write data
- s_wstrb_i  in  (DATA_W/8)*N_SLAVES  packed strobes; nonzero = write request, zero = read request
- s_len_i  in  LEN_W*N_SLAVES  packed burst lengths
- s_rdata_o  out  DATA_W  read data, broadcast to all slaves
- m_wvalid_o, m_waddr_o, m_wdata_o, m_wstrb_o, m_wlen_o  out  1/ADDR_W/DATA_W/DATA_W/8/LEN_W  write channel
- m_wready_i, m_wlast_i  in  1  write handshake / last
- m_rvalid_o, m_raddr_o, m_rlen_o  out  1/ADDR_W/LEN_W  read channel
- m_rready_i, m_rlast_i  in  1  read handshake / last
- m_rdata_i  in  DATA_W  read data
- w_busy_o, r_busy_o  out  1  channel holds a grant
- err_o  out  1  sticky last-mismatch flag (see Configuration)

## Operation
- Each channel (W, R) runs an identical 2-state FSM: IDLE, BUSY.
- IDLE: request set = slaves with s_valid_i set and matching class (write if |wstrb, else read). If nonempty, grant = first requester at or after rr_ptr, scanning upward modulo N_SLAVES. Latch grant index, go BUSY.
- BUSY: forward granted slave's live valid/addr/wdata/wstrb/len to master. Other channel fields are 0. In IDLE all m_* outputs are 0.
- Transfer = m_xvalid_o && m_xready_i. On a transfer with m_xlast_i: go IDLE and set rr_ptr = grant+1 (wraps to 0 past N_SLAVES-1).
- s_ready_o[g] = busy && m_xready_i. s_last_o[g] = busy && m_xlast_i. Both channels OR into the per-slave vectors. s_rdata_o = m_rdata_i combinationally.
- A slave dropping s_valid_i while granted keeps the grant. m_xvalid_o follows it low, and the burst resumes when it reasserts.
- Read and write channels are fully independent and may both be BUSY, including for the same slave index on different classes.
- N_SLAVES=1: arbitration degenerates, rr_ptr is held at 0.

## Timing
- Reset: FSMs IDLE, rr_ptr=0, grant=0, err_o=0. All m_* outputs, s_ready_o, s_last_o, w_busy_o and r_busy_o are 0.
- Grant latency: request sampled in IDLE at edge N, so m_xvalid_o is high from cycle N+1.
- Release: the last transfer at edge M means IDLE in cycle M+1 and the earliest next grant at edge M+1. There is a minimum one-cycle bubble between bursts on a channel.
- Simultaneous requests: exactly one granted per channel, per the rr_ptr order.
- Reset asserted mid-burst: channel returns to IDLE next edge and the burst is abandoned.
- m_xlast_i while IDLE or without a transfer is ignored.

## Configuration
- XMERGE_RR_LAST_CHECK_EN defined: at grant, latch len into a per-channel beat counter, then count transfers. err_o sets (sticky until reset) if m_xlast_i arrives on a transfer whose count ≠ len, or if count reaches len without m_xlast_i.
- Not defined: no counters, and err_o is tied 0.

## Structure
- Header xmerge_rr.vh: FSM state localparams (IDLE=1'b0, BUSY=1'b1) and the SLV_W derivation macro.
- Sub-module xmerge_rr_arb: round-robin pointer, IDLE/BUSY FSM, grant latch and optional beat counter. Instanced once per channel with req vector, transfer and last inputs.

## Test plan
- Reset: hold rst_i 3 cycles with all slaves valid → all outputs 0. Slave 0 write (wstrb=4'hF, len=3) granted with m_wvalid_o high 1 cycle after release.
- Fairness: slaves 0–3 request writes continuously with len=0 → grant order 0,1,2,3,0 with one bubble cycle between each.
- Concurrency: slave 1 reads (len=7) while slave 2 writes (len=3) → both channels BUSY together. Each s_ready_o bit is correct and r_busy_o drops after the 8th read beat.
- Backpressure/drop: m_wready_i toggling each cycle and slave valid dropped for 2 cycles mid-burst → grant retained, exactly len+1 beats pass, and addr/data match the slave.
- Mid-burst reset: assert rst_i during beat 2 of 4 → next cycle all outputs 0 and rr_ptr=0.
- With XMERGE_RR_LAST_CHECK_EN: len=3 but m_wlast_i on beat 2 → err_o=1 and stays set. Without the macro the same stimulus gives err_o=0.

Source files
------------

// File: rtl/xmerge_rr_pkg.sv
// Shared state type and slave-index width helper for the xmerge_rr round-robin merge.
package xmerge_rr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int slv_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xmerge_rr_arb.sv
// Per-channel round-robin arbiter: IDLE/BUSY grant lock, rotating pointer and,
// when XMERGE_RR_LAST_CHECK_EN is defined, a beat counter that flags last mismatches.
module xmerge_rr_arb
  import xmerge_rr_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int LEN_W    = 8,
  parameter int SLV_W    = slv_width(N_SLAVES)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_SLAVES-1:0]       req,
  input  logic [LEN_W*N_SLAVES-1:0] len_all,
  input  logic                      xfer,
  input  logic                      last,
  output logic                      busy,
  output logic [SLV_W-1:0]          grant,
  output logic                      err
);

  arb_state_e       state;
  logic [SLV_W-1:0] rr_ptr;
  logic [SLV_W-1:0] pick;
  logic [SLV_W-1:0] cand;
  logic [SLV_W-1:0] next_ptr;
  logic             found;

  // First requester at or after rr_ptr, scanning upward with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      cand = SLV_W'((int'(rr_ptr) + i) % N_SLAVES);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign next_ptr = (grant == SLV_W'(N_SLAVES - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (xfer && last) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == BUSY);

`ifdef XMERGE_RR_LAST_CHECK_EN
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic             err_q;

  // Last must coincide exactly with the beat whose index equals the latched len.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q    <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else if (state == IDLE) begin
      if (found) begin
        len_q    <= len_all[pick*LEN_W +: LEN_W];
        beat_cnt <= '0;
      end
    end else if (xfer) begin
      if (last != (beat_cnt == len_q)) begin
        err_q <= 1'b1;
      end
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_len;
  assign unused_len = ^len_all;
  assign err        = 1'b0;
`endif

endmodule

// File: rtl/xmerge_rr.sv
// Round-robin N-to-1 merge of Versat memory requests onto independent master read/write
// channels. Optional last-beat checking is enabled with XMERGE_RR_LAST_CHECK_EN.
module xmerge_rr
  import xmerge_rr_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 4,
  parameter int LEN_W    = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_SLAVES-1:0]              s_valid_i,
  output logic [N_SLAVES-1:0]              s_ready_o,
  output logic [N_SLAVES-1:0]              s_last_o,
  input  logic [ADDR_W*N_SLAVES-1:0]       s_addr_i,
  input  logic [DATA_W*N_SLAVES-1:0]       s_wdata_i,
  input  logic [(DATA_W/8)*N_SLAVES-1:0]   s_wstrb_i,
  input  logic [LEN_W*N_SLAVES-1:0]        s_len_i,
  output logic [DATA_W-1:0]                s_rdata_o,
  output logic                             m_wvalid_o,
  output logic [ADDR_W-1:0]                m_waddr_o,
  output logic [DATA_W-1:0]                m_wdata_o,
  output logic [DATA_W/8-1:0]              m_wstrb_o,
  output logic [LEN_W-1:0]                 m_wlen_o,
  input  logic                             m_wready_i,
  input  logic                             m_wlast_i,
  output logic                             m_rvalid_o,
  output logic [ADDR_W-1:0]                m_raddr_o,
  output logic [LEN_W-1:0]                 m_rlen_o,
  input  logic                             m_rready_i,
  input  logic                             m_rlast_i,
  input  logic [DATA_W-1:0]                m_rdata_i,
  output logic                             w_busy_o,
  output logic                             r_busy_o,
  output logic                             err_o
);

  localparam int SLV_W  = slv_width(N_SLAVES);
  localparam int STRB_W = DATA_W / 8;

  logic [N_SLAVES-1:0] w_req, r_req;
  logic [SLV_W-1:0]    w_grant, r_grant;
  logic                w_busy, r_busy, w_err, r_err;

  // A request with any strobe bit set belongs to the write channel, otherwise to read.
  always_comb begin
    w_req = '0;
    r_req = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      w_req[k] = s_valid_i[k] & (|s_wstrb_i[k*STRB_W +: STRB_W]);
      r_req[k] = s_valid_i[k] & ~(|s_wstrb_i[k*STRB_W +: STRB_W]);
    end
  end

  xmerge_rr_arb #(.N_SLAVES(N_SLAVES), .LEN_W(LEN_W), .SLV_W(SLV_W)) w_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (w_req),
    .len_all (s_len_i),
    .xfer    (m_wvalid_o & m_wready_i),
    .last    (m_wlast_i),
    .busy    (w_busy),
    .grant   (w_grant),
    .err     (w_err)
  );

  xmerge_rr_arb #(.N_SLAVES(N_SLAVES), .LEN_W(LEN_W), .SLV_W(SLV_W)) r_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (r_req),
    .len_all (s_len_i),
    .xfer    (m_rvalid_o & m_rready_i),
    .last    (m_rlast_i),
    .busy    (r_busy),
    .grant   (r_grant),
    .err     (r_err)
  );

  // The granted slave's live signals pass straight through, so a dropped valid stalls the burst.
  always_comb begin
    m_wvalid_o = 1'b0;
    m_waddr_o  = '0;
    m_wdata_o  = '0;
    m_wstrb_o  = '0;
    m_wlen_o   = '0;
    m_rvalid_o = 1'b0;
    m_raddr_o  = '0;
    m_rlen_o   = '0;
    s_ready_o  = '0;
    s_last_o   = '0;
    if (w_busy) begin
      m_wvalid_o         = s_valid_i[w_grant];
      m_waddr_o          = s_addr_i[w_grant*ADDR_W +: ADDR_W];
      m_wdata_o          = s_wdata_i[w_grant*DATA_W +: DATA_W];
      m_wstrb_o          = s_wstrb_i[w_grant*STRB_W +: STRB_W];
      m_wlen_o           = s_len_i[w_grant*LEN_W +: LEN_W];
      s_ready_o[w_grant] = m_wready_i;
      s_last_o[w_grant]  = m_wlast_i;
    end
    if (r_busy) begin
      m_rvalid_o         = s_valid_i[r_grant];
      m_raddr_o          = s_addr_i[r_grant*ADDR_W +: ADDR_W];
      m_rlen_o           = s_len_i[r_grant*LEN_W +: LEN_W];
      s_ready_o[r_grant] = s_ready_o[r_grant] | m_rready_i;
      s_last_o[r_grant]  = s_last_o[r_grant] | m_rlast_i;
    end
  end

  assign s_rdata_o = m_rdata_i;
  assign w_busy_o  = w_busy;
  assign r_busy_o  = r_busy;
  assign err_o     = w_err | r_err;

endmodule

// File: tb/tb_xmerge_rr.sv
// Scoreboard bench for xmerge_rr: expected beats are queued as stimulus is set up and
// retired as the master port transfers them.
module tb_xmerge_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int SW = DW / 8;

  typedef struct {
    int          slave;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  len;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [N-1:0]  s_valid_i, s_ready_o, s_last_o;
  logic [AW*N-1:0] s_addr_i;
  logic [DW*N-1:0] s_wdata_i;
  logic [SW*N-1:0] s_wstrb_i;
  logic [LW*N-1:0] s_len_i;
  logic [DW-1:0] s_rdata_o;
  logic          m_wvalid_o, m_wready_i, m_wlast_i;
  logic [AW-1:0] m_waddr_o;
  logic [DW-1:0] m_wdata_o;
  logic [SW-1:0] m_wstrb_o;
  logic [LW-1:0] m_wlen_o;
  logic          m_rvalid_o, m_rready_i, m_rlast_i;
  logic [AW-1:0] m_raddr_o;
  logic [LW-1:0] m_rlen_o;
  logic [DW-1:0] m_rdata_i;
  logic          w_busy_o, r_busy_o, err_o;

  int    checks   = 0;
  int    failures = 0;
  beat_t wq[$];
  beat_t rq[$];

  always #5 clk = ~clk;

  xmerge_rr #(.ADDR_W(AW), .DATA_W(DW), .N_SLAVES(N), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_last_o(s_last_o),
    .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_len_i(s_len_i),
    .s_rdata_o(s_rdata_o),
    .m_wvalid_o(m_wvalid_o), .m_waddr_o(m_waddr_o), .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o), .m_wlen_o(m_wlen_o), .m_wready_i(m_wready_i), .m_wlast_i(m_wlast_i),
    .m_rvalid_o(m_rvalid_o), .m_raddr_o(m_raddr_o), .m_rlen_o(m_rlen_o),
    .m_rready_i(m_rready_i), .m_rlast_i(m_rlast_i), .m_rdata_i(m_rdata_i),
    .w_busy_o(w_busy_o), .r_busy_o(r_busy_o), .err_o(err_o)
  );

  function automatic logic [31:0] slave_addr(input int k);
    return 32'h1000_0000 + (32'(k) << 8);
  endfunction

  function automatic logic [N-1:0] onehot(input int k);
    return N'(1 << k);
  endfunction

  task automatic set_slave(input int k, input logic v, input logic wr,
                           input logic [7:0] len, input logic [31:0] data);
    s_valid_i[k]          = v;
    s_addr_i[k*AW +: AW]  = slave_addr(k);
    s_wdata_i[k*DW +: DW] = data;
    s_wstrb_i[k*SW +: SW] = wr ? 4'hF : 4'h0;
    s_len_i[k*LW +: LW]   = len;
  endtask

  task automatic push_beats(ref beat_t q[$], input int k, input logic [31:0] data0,
                            input int inc, input logic [7:0] len);
    beat_t b;
    for (int i = 0; i <= int'(len); i++) begin
      b.slave = k;
      b.addr  = slave_addr(k);
      b.data  = data0 + 32'(i * inc);
      b.len   = len;
      q.push_back(b);
    end
  endtask

  task automatic test_reset();
    beat_t e;
    int    beats;
    rst_i = 1'b1;
    for (int k = 0; k < N; k++) set_slave(k, 1'b1, 1'b1, 8'd0, 32'h0);
    m_wready_i = 1'b1; m_wlast_i = 1'b1; m_rready_i = 1'b1; m_rlast_i = 1'b1;
    m_rdata_i  = '0;
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if ({m_wvalid_o, m_rvalid_o, m_waddr_o, m_wdata_o, m_wstrb_o, m_wlen_o, m_raddr_o,
           m_rlen_o, s_ready_o, s_last_o, w_busy_o, r_busy_o, err_o} !== '0) begin
        failures++;
        $display("[TB] FAIL reset_outputs got wv=%b rv=%b rdy=%b lst=%b wb=%b rb=%b err=%b required all 0",
                 m_wvalid_o, m_rvalid_o, s_ready_o, s_last_o, w_busy_o, r_busy_o, err_o);
      end
    end
    @(negedge clk);
    rst_i = 1'b0;
    s_valid_i = '0;
    set_slave(0, 1'b1, 1'b1, 8'd3, 32'hD0D0_0000);
    m_wlast_i = 1'b0; m_rlast_i = 1'b0;
    push_beats(wq, 0, 32'hD0D0_0000, 0, 8'd3);
    #1;
    checks++;
    if (m_wvalid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release_idle got m_wvalid=%b required 0", m_wvalid_o);
    end
    beats = 0;
    for (int cyc = 0; cyc < 16 && beats < 4; cyc++) begin
      @(negedge clk);
      m_wlast_i = (beats == 3);
      #1;
      if (cyc == 0) begin
        checks++;
        if (m_wvalid_o !== 1'b1) begin
          failures++;
          $display("[TB] FAIL grant_latency got m_wvalid=%b required 1", m_wvalid_o);
        end
      end
      if (m_wvalid_o && m_wready_i) begin
        e = wq.pop_front();
        checks++;
        if ({m_waddr_o, m_wdata_o, m_wlen_o, s_ready_o} !== {e.addr, e.data, e.len, onehot(e.slave)}) begin
          failures++;
          $display("[TB] FAIL reset_burst_beat got addr=%h data=%h len=%0d rdy=%b required addr=%h data=%h len=%0d rdy=%b",
                   m_waddr_o, m_wdata_o, m_wlen_o, s_ready_o, e.addr, e.data, e.len, onehot(e.slave));
        end
        beats++;
      end
    end
    checks++;
    if (beats != 4) begin
      failures++;
      $display("[TB] FAIL reset_burst_count got %0d beats required 4", beats);
    end
    @(negedge clk);
    s_valid_i = '0; m_wlast_i = 1'b0;
    #1;
    checks++;
    if ({w_busy_o, err_o} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_burst_release got busy=%b err=%b required 0 0", w_busy_o, err_o);
    end
    wq.delete();
  endtask

  task automatic test_fairness();
    int gq[$];
    int last_cyc;
    int g;
    gq = '{0, 1, 2, 3, 0};
    for (int k = 0; k < N; k++) set_slave(k, 1'b1, 1'b1, 8'd0, 32'hFA00_0000 + 32'(k));
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    m_wready_i = 1'b1; m_wlast_i = 1'b1;
    last_cyc = -1;
    for (int cyc = 0; cyc < 40 && gq.size() > 0; cyc++) begin
      @(negedge clk); #1;
      if (m_wvalid_o) begin
        g = gq.pop_front();
        checks++;
        if ({s_ready_o, m_waddr_o, m_wdata_o} !== {onehot(g), slave_addr(g), 32'hFA00_0000 + 32'(g)}) begin
          failures++;
          $display("[TB] FAIL fair_order got rdy=%b addr=%h required rdy=%b addr=%h",
                   s_ready_o, m_waddr_o, onehot(g), slave_addr(g));
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 2) begin
            failures++;
            $display("[TB] FAIL fair_bubble got gap=%0d required 2", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
      end
    end
    checks++;
    if (gq.size() != 0) begin
      failures++;
      $display("[TB] FAIL fair_timeout got %0d grants pending required 0", gq.size());
    end
    @(negedge clk);
    s_valid_i = '0; m_wlast_i = 1'b0;
  endtask

  task automatic test_concurrency();
    beat_t e;
    int    wb, rb;
    logic  wact, ract;
    logic [N-1:0] exp_rdy, exp_lst;
    set_slave(1, 1'b1, 1'b0, 8'd7, 32'h0);
    set_slave(2, 1'b1, 1'b1, 8'd3, 32'hC2C2_0000);
    push_beats(wq, 2, 32'hC2C2_0000, 0, 8'd3);
    push_beats(rq, 1, 32'h0, 0, 8'd7);
    wb = 0; rb = 0;
    for (int cyc = 0; cyc < 40 && (wb < 4 || rb < 8); cyc++) begin
      @(negedge clk);
      wact = (wb < 4); ract = (rb < 8);
      s_valid_i[2] = wact; s_valid_i[1] = ract;
      m_wready_i = 1'b1; m_rready_i = 1'b1;
      m_wlast_i = (wb == 3); m_rlast_i = (rb == 7);
      m_rdata_i = $urandom;
      #1;
      if (cyc == 0) begin
        checks++;
        if ({w_busy_o, r_busy_o} !== 2'b11) begin
          failures++;
          $display("[TB] FAIL conc_both_busy got w=%b r=%b required 1 1", w_busy_o, r_busy_o);
        end
      end
      exp_rdy = '0; exp_lst = '0;
      exp_rdy[2] = wact; exp_rdy[1] = ract;
      exp_lst[2] = wact & m_wlast_i; exp_lst[1] = ract & m_rlast_i;
      checks++;
      if ({s_ready_o, s_last_o} !== {exp_rdy, exp_lst}) begin
        failures++;
        $display("[TB] FAIL conc_ready_last got rdy=%b lst=%b required rdy=%b lst=%b",
                 s_ready_o, s_last_o, exp_rdy, exp_lst);
      end
      if (m_wvalid_o && m_wready_i) begin
        e = wq.pop_front();
        checks++;
        if ({m_waddr_o, m_wdata_o, m_wlen_o} !== {e.addr, e.data, e.len}) begin
          failures++;
          $display("[TB] FAIL conc_write_beat got addr=%h data=%h required addr=%h data=%h",
                   m_waddr_o, m_wdata_o, e.addr, e.data);
        end
        wb++;
      end
      if (m_rvalid_o && m_rready_i) begin
        e = rq.pop_front();
        checks++;
        if ({m_raddr_o, m_rlen_o, s_rdata_o} !== {e.addr, e.len, m_rdata_i}) begin
          failures++;
          $display("[TB] FAIL conc_read_beat got addr=%h len=%0d rdata=%h required addr=%h len=%0d rdata=%h",
                   m_raddr_o, m_rlen_o, s_rdata_o, e.addr, e.len, m_rdata_i);
        end
        rb++;
      end
    end
    @(negedge clk);
    s_valid_i = '0; m_wlast_i = 1'b0; m_rlast_i = 1'b0;
    #1;
    checks++;
    if ({wb, rb, r_busy_o, w_busy_o} !== {32'd4, 32'd8, 2'b00}) begin
      failures++;
      $display("[TB] FAIL conc_release got wb=%0d rb=%0d rbusy=%b wbusy=%b required 4 8 0 0",
               wb, rb, r_busy_o, w_busy_o);
    end
  endtask

  task automatic test_back_pressure();
    beat_t e;
    int    beats, drop;
    bit    dropped;
    set_slave(3, 1'b1, 1'b1, 8'd3, 32'hB000_0000);
    push_beats(wq, 3, 32'hB000_0000, 1, 8'd3);
    beats = 0; drop = 0; dropped = 1'b0;
    for (int cyc = 0; cyc < 60 && beats < 4; cyc++) begin
      @(negedge clk);
      if (beats == 2 && !dropped) begin
        drop = 2; dropped = 1'b1;
      end
      s_valid_i[3] = (drop == 0);
      s_wdata_i[3*DW +: DW] = 32'hB000_0000 + 32'(beats);
      m_wready_i = cyc[0];
      m_wlast_i  = (beats == 3);
      #1;
      if (drop > 0) begin
        checks++;
        if ({m_wvalid_o, w_busy_o} !== 2'b01) begin
          failures++;
          $display("[TB] FAIL bp_drop_hold got wvalid=%b busy=%b required 0 1", m_wvalid_o, w_busy_o);
        end
        drop--;
      end
      if (m_wvalid_o && m_wready_i) begin
        e = wq.pop_front();
        checks++;
        if ({m_waddr_o, m_wdata_o, s_ready_o} !== {e.addr, e.data, onehot(3)}) begin
          failures++;
          $display("[TB] FAIL bp_beat got addr=%h data=%h rdy=%b required addr=%h data=%h rdy=%b",
                   m_waddr_o, m_wdata_o, s_ready_o, e.addr, e.data, onehot(3));
        end
        beats++;
      end
    end
    @(negedge clk);
    s_valid_i = '0; m_wlast_i = 1'b0; m_wready_i = 1'b1;
    #1;
    checks++;
    if ({beats, w_busy_o} !== {32'd4, 1'b0}) begin
      failures++;
      $display("[TB] FAIL bp_count got beats=%0d busy=%b required 4 0", beats, w_busy_o);
    end
  endtask

  task automatic test_mid_reset();
    int beats;
    bit seen;
    set_slave(1, 1'b1, 1'b1, 8'd0, 32'h1111_0000);
    m_wready_i = 1'b1; m_wlast_i = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk); #1;
      if (m_wvalid_o) seen = 1'b1;
    end
    @(negedge clk);
    s_valid_i = '0; m_wlast_i = 1'b0;
    set_slave(2, 1'b1, 1'b1, 8'd3, 32'h2222_0000);
    beats = 0;
    for (int cyc = 0; cyc < 20 && rst_i == 1'b0; cyc++) begin
      @(negedge clk);
      if (beats == 1) rst_i = 1'b1;
      #1;
      if (m_wvalid_o && m_wready_i) beats++;
    end
    @(negedge clk); #1;
    checks++;
    if ({seen, m_wvalid_o, m_rvalid_o, m_waddr_o, m_wdata_o, s_ready_o, s_last_o, w_busy_o, r_busy_o, err_o}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got seen=%b wv=%b rdy=%b busy=%b err=%b required seen=1 rest 0",
               seen, m_wvalid_o, s_ready_o, w_busy_o, err_o);
    end
    rst_i = 1'b0;
    for (int k = 0; k < N; k++) set_slave(k, 1'b1, 1'b1, 8'd0, 32'h3333_0000);
    m_wlast_i = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({m_wvalid_o, s_ready_o} !== {1'b1, onehot(0)}) begin
      failures++;
      $display("[TB] FAIL midreset_ptr got wv=%b rdy=%b required wv=1 rdy=%b", m_wvalid_o, s_ready_o, onehot(0));
    end
    @(negedge clk);
    s_valid_i = '0; m_wlast_i = 1'b0;
  endtask

  task automatic test_last_check();
    int   beats;
    logic exp_err;
`ifdef XMERGE_RR_LAST_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    #1;
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_before got %b required 0", err_o);
    end
    set_slave(0, 1'b1, 1'b1, 8'd3, 32'hE0E0_0000);
    m_wready_i = 1'b1;
    beats = 0;
    for (int cyc = 0; cyc < 20 && beats < 2; cyc++) begin
      @(negedge clk);
      m_wlast_i = (beats == 1);
      #1;
      if (m_wvalid_o && m_wready_i) beats++;
    end
    @(negedge clk);
    s_valid_i = '0; m_wlast_i = 1'b0;
    #1;
    checks++;
    if ({beats, w_busy_o, err_o} !== {32'd2, 1'b0, exp_err}) begin
      failures++;
      $display("[TB] FAIL last_err got beats=%0d busy=%b err=%b required 2 0 %b", beats, w_busy_o, err_o, exp_err);
    end
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (err_o !== exp_err) begin
        failures++;
        $display("[TB] FAIL last_err_sticky got %b required %b", err_o, exp_err);
      end
    end
  endtask

  initial begin
    s_valid_i = '0; s_addr_i = '0; s_wdata_i = '0; s_wstrb_i = '0; s_len_i = '0;
    m_wready_i = 1'b0; m_wlast_i = 1'b0; m_rready_i = 1'b0; m_rlast_i = 1'b0; m_rdata_i = '0;
    test_reset();
    test_fairness();
    test_concurrency();
    test_back_pressure();
    test_mid_reset();
    test_last_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
